i2c_arbiter: RTL and testbench

//  Shares the single i2c master (data/en in, st/out_i2c out) between N_REQ client FSMs (at24c32 EEPROM, RTC, ...).

---
 rtl/enum_t.sv | 11 +
 rtl/i2c_arbiter_pkg.sv | 18 +
 rtl/i2c_arbiter_rr_pick.sv | 44 ++++
 rtl/i2c_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/enum_t.sv
// Shared i2c master status encoding used by the master and every client FSM.
package enum_t;

    typedef enum logic [1:0] {
        ACK  = 2'd0,
        SEND = 2'd1,
        STOP = 2'd2,
        HOLD = 2'd3
    } i2c_t;

endpackage

// File: rtl/i2c_arbiter_pkg.sv
// Types and constants for the i2c master arbiter.
package i2c_arb_pkg;

    import enum_t::*;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    // Parked status shown to clients that do not own the master.
    localparam i2c_t ST_HOLD = HOLD;

    localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request after ptr, wrapping modulo N.
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int step);
        int k;
        k = int'(p) + step;
        if (k >= N) begin
            k = k - N;
        end else begin
            k = k;
        end
        return k[IW-1:0];
    endfunction

    // Scan from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[rot(ptr, i)]) begin
                valid = 1'b1;
                idx   = rot(ptr, i);
            end else begin
                valid = valid;
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin owner of the single i2c master; holds a grant for a whole
// transaction and recovers hung clients or a stuck bus by watchdog.
module i2c_arbiter
    import enum_t::*;
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int GRANT_TMO = 1024,
    parameter int ACT_TMO   = 250000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      en_in,
    input  logic [N_REQ-1:0][7:0] data_in,
    output logic [N_REQ-1:0]      gnt,
    output i2c_t [N_REQ-1:0]      st_out,
    output logic [N_REQ-1:0][7:0] rd_data,
    output logic                  i2c_en,
    output logic [7:0]            i2c_data,
    input  i2c_t                  i2c_st,
    input  logic [7:0]            i2c_rd,
    output logic                  busy,
    output logic                  tmo_err
);

    localparam int TMO_W  = $clog2(ACT_TMO + 1);
    localparam int GTMO_W = $clog2(GRANT_TMO + 1);
    localparam int CNT_W  = (TMO_W > GTMO_W) ? TMO_W : GTMO_W;
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] GRANT_LIM = CNT_W'(GRANT_TMO - 1);
    localparam logic [CNT_W-1:0] ACT_LIM   = CNT_W'(ACT_TMO - 1);

    arb_state_t            state_q, state_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  stop_seen_q, stop_seen_d;
    logic                  stop_wait_q, stop_wait_d;
    logic                  tmo_err_q, tmo_err_d;
    i2c_t                  st_prev_q;
    logic [N_REQ-1:0][7:0] rd_data_q, rd_data_d;

    logic                  pick_valid;
    logic [N_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  en_g, req_g, st_change, stop_now, stop_edge;
    logic                  release_s, route_st, en_mux;
    logic [7:0]            data_mux;

    rr_pick #(.N(N_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign en_g      = en_in[idx_q];
    assign req_g     = req[idx_q];
    assign st_change = (i2c_st != st_prev_q);
    assign stop_now  = stop_seen_q || (i2c_st == STOP);
    assign stop_edge = (i2c_st == STOP) && (st_prev_q != STOP) && (state_q != IDLE);

    // Next-state, watchdog and master-side mux.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        stop_seen_d = stop_seen_q;
        stop_wait_d = stop_wait_q;
        tmo_err_d   = 1'b0;
        release_s   = 1'b0;
        route_st    = 1'b0;
        en_mux      = 1'b0;
        data_mux    = 8'h00;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end else begin
                    cnt_d = '0;
                end
            end
            GRANT: begin
                en_mux   = en_g;
                data_mux = data_in[idx_q];
                if (en_g) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (!req_g) begin
                    release_s = 1'b1;
                end else if (cnt_q == GRANT_LIM) begin
                    release_s = 1'b1;
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACTIVE: begin
                route_st = 1'b1;
                data_mux = data_in[idx_q];
                if (!st_change && (cnt_q == ACT_LIM)) begin
                    // Stuck master: en is withheld this cycle and the bus drained.
                    tmo_err_d   = 1'b1;
                    state_d     = DRAIN;
                    cnt_d       = '0;
                    stop_seen_d = 1'b0;
                    stop_wait_d = 1'b0;
                end else begin
                    en_mux = en_g;
                    cnt_d  = st_change ? '0 : (cnt_q + CNT_W'(1));
                    if (!en_g) begin
                        state_d     = DRAIN;
                        cnt_d       = '0;
                        stop_seen_d = 1'b0;
                        stop_wait_d = 1'b0;
                    end else begin
                        state_d = ACTIVE;
                    end
                end
            end
            DRAIN: begin
                route_st = 1'b1;
                if (cnt_q == ACT_LIM) begin
                    release_s = 1'b1;
                    tmo_err_d = 1'b1;
                end else if (stop_now && en_g) begin
                    state_d     = ACTIVE;
                    cnt_d       = '0;
                    stop_seen_d = 1'b0;
                    stop_wait_d = 1'b0;
                end else if (stop_seen_q && stop_wait_q) begin
                    release_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (stop_seen_q) begin
                        stop_wait_d = 1'b1;
                    end else begin
                        stop_seen_d = (i2c_st == STOP);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        if (release_s) begin
            gnt_d       = '0;
            ptr_d       = idx_q;
            state_d     = IDLE;
            cnt_d       = '0;
            stop_seen_d = 1'b0;
            stop_wait_d = 1'b0;
        end else begin
            ptr_d = ptr_d;
        end
    end

    // Read byte is latched on the cycle the master first reports STOP.
    always_comb begin
        rd_data_d = rd_data_q;
        if (stop_edge) begin
            rd_data_d[idx_q] = i2c_rd;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Status is routed only to the owner while it is on the bus.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            if (route_st && (idx_q == IDX_W'(k))) begin
                st_out[k] = i2c_st;
            end else begin
                st_out[k] = ST_HOLD;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            idx_q       <= '0;
            ptr_q       <= IDX_W'(N_REQ - 1);
            cnt_q       <= '0;
            stop_seen_q <= 1'b0;
            stop_wait_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            st_prev_q   <= ST_HOLD;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            stop_seen_q <= stop_seen_d;
            stop_wait_q <= stop_wait_d;
            tmo_err_q   <= tmo_err_d;
            st_prev_q   <= i2c_st;
            rd_data_q   <= rd_data_d;
        end
    end

    assign gnt      = gnt_q;
    assign rd_data  = rd_data_q;
    assign i2c_en   = en_mux;
    assign i2c_data = data_mux;
    assign busy     = (state_q != IDLE);
    assign tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: grant latency, round-robin, both timeouts,
// read-byte capture with phase chaining, and reset mid-transaction.
module tb_i2c_arbiter;

    import enum_t::*;

    localparam int N         = 2;
    localparam int GRANT_TMO = 1024;
    localparam int ACT_TMO   = 200;

    logic             clk_s = 1'b0;
    logic             rst_n_s;
    logic [N-1:0]     req_s;
    logic [N-1:0]     en_in_s;
    logic [N-1:0][7:0] data_in_s;
    logic [N-1:0]     gnt_s;
    i2c_t [N-1:0]     st_out_s;
    logic [N-1:0][7:0] rd_data_s;
    logic             i2c_en_s;
    logic [7:0]       i2c_data_s;
    i2c_t             i2c_st_s;
    logic [7:0]       i2c_rd_s;
    logic             busy_s;
    logic             tmo_err_s;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc;

    i2c_arbiter #(.N_REQ(N), .GRANT_TMO(GRANT_TMO), .ACT_TMO(ACT_TMO)) dut (
        .clk      (clk_s),
        .rst_n    (rst_n_s),
        .req      (req_s),
        .en_in    (en_in_s),
        .data_in  (data_in_s),
        .gnt      (gnt_s),
        .st_out   (st_out_s),
        .rd_data  (rd_data_s),
        .i2c_en   (i2c_en_s),
        .i2c_data (i2c_data_s),
        .i2c_st   (i2c_st_s),
        .i2c_rd   (i2c_rd_s),
        .busy     (busy_s),
        .tmo_err  (tmo_err_s)
    );

    always #5 clk_s = ~clk_s;

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_s);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One single-byte write by client 'who' while the other request may stay up.
    task automatic do_txn(input int who, input logic [7:0] wb, input logic [7:0] rdv);
        int w;
        w = 0;
        while ((gnt_s == '0) && (w < 20)) begin
            tick();
            w++;
        end
        chk("rr_gnt", gnt_s, 32'(1) << who);
        en_in_s[who]   = 1'b1;
        data_in_s[who] = wb;
        tick();
        i2c_st_s = SEND;
        #1;
        chk("rr_data", i2c_data_s, wb);
        tick();
        en_in_s[who] = 1'b0;
        tick();
        i2c_st_s = STOP;
        i2c_rd_s = rdv;
        tick();
        tick();
        tick();
        chk("rr_release", gnt_s, 32'd0);
        chk("rr_rd", rd_data_s[who], rdv);
        i2c_st_s = HOLD;
    endtask

    initial begin
        rst_n_s   = 1'b0;
        req_s     = '0;
        en_in_s   = '0;
        data_in_s = '0;
        i2c_st_s  = HOLD;
        i2c_rd_s  = 8'h00;
        tick();
        tick();
        chk("rst_gnt", gnt_s, 32'd0);
        chk("rst_busy", busy_s, 32'd0);
        chk("rst_en", i2c_en_s, 32'd0);
        chk("rst_data", i2c_data_s, 32'd0);
        chk("rst_tmo", tmo_err_s, 32'd0);
        chk("rst_st0", st_out_s[0], HOLD);
        chk("rst_rd", rd_data_s, 32'd0);
        rst_n_s = 1'b1;
        tick();

        // 1: client0 two-byte write
        req_s = 2'b01;
        tick();
        chk("t1_gnt_latency", gnt_s, 32'h1);
        chk("t1_busy", busy_s, 32'd1);
        en_in_s[0]   = 1'b1;
        data_in_s[0] = 8'h3C;
        #1;
        chk("t1_en_same_cycle", i2c_en_s, 32'd1);
        chk("t1_data_same_cycle", i2c_data_s, 32'h3C);
        tick();
        i2c_st_s = SEND;
        #1;
        chk("t1_st_routed", st_out_s[0], SEND);
        chk("t1_st_other_hold", st_out_s[1], HOLD);
        tick();
        i2c_st_s     = ACK;
        data_in_s[0] = 8'h5A;
        #1;
        chk("t1_data_byte2", i2c_data_s, 32'h5A);
        tick();
        en_in_s[0] = 1'b0;
        req_s      = 2'b00;
        #1;
        chk("t1_en_fall", i2c_en_s, 32'd0);
        tick();
        i2c_st_s = STOP;
        i2c_rd_s = 8'h11;
        chk("t1_drain_gnt", gnt_s, 32'h1);
        tick();
        tick();
        chk("t1_window_gnt", gnt_s, 32'h1);
        tick();
        chk("t1_released", gnt_s, 32'd0);
        chk("t1_idle", busy_s, 32'd0);
        chk("t1_rd", rd_data_s[0], 32'h11);
        i2c_st_s = HOLD;

        // 2: both request continuously, strict alternation starting after ptr=0
        req_s = 2'b11;
        do_txn(1, 8'h01, 8'h21);
        do_txn(0, 8'h02, 8'h30);
        do_txn(1, 8'h03, 8'h22);
        do_txn(0, 8'h04, 8'h31);

        // 3: client1 granted but never enables
        tick();
        chk("t3_gnt1", gnt_s, 32'h2);
        n_cyc = 0;
        while ((gnt_s == 2'b10) && (n_cyc < 2000)) begin
            n_cyc++;
            tick();
        end
        chk("t3_grant_cycles", n_cyc, GRANT_TMO);
        chk("t3_tmo_pulse", tmo_err_s, 32'd1);
        chk("t3_gnt_off", gnt_s, 32'd0);
        tick();
        chk("t3_tmo_one_cycle", tmo_err_s, 32'd0);
        chk("t3_next_gnt0", gnt_s, 32'h1);
        req_s = 2'b00;
        tick();
        chk("t3_voluntary_release", gnt_s, 32'd0);
        chk("t3_no_tmo", tmo_err_s, 32'd0);

        // 4: master frozen at SEND while active
        req_s = 2'b01;
        tick();
        chk("t4_gnt", gnt_s, 32'h1);
        i2c_st_s     = SEND;
        en_in_s[0]   = 1'b1;
        data_in_s[0] = 8'h77;
        tick();
        n_cyc = 0;
        while ((i2c_en_s === 1'b1) && (n_cyc < 500)) begin
            n_cyc++;
            tick();
        end
        chk("t4_active_cycles", n_cyc, ACT_TMO - 1);
        chk("t4_tmo_not_yet", tmo_err_s, 32'd0);
        tick();
        chk("t4_tmo_pulse", tmo_err_s, 32'd1);
        chk("t4_en_forced", i2c_en_s, 32'd0);
        chk("t4_drain_held", gnt_s, 32'h1);
        en_in_s  = '0;
        req_s    = '0;
        i2c_st_s = STOP;
        i2c_rd_s = 8'h44;
        tick();
        tick();
        tick();
        chk("t4_idle", busy_s, 32'd0);
        chk("t4_gnt_off", gnt_s, 32'd0);
        chk("t4_rd", rd_data_s[0], 32'h44);
        i2c_st_s = HOLD;

        // 5: read txn with chained phase one cycle after STOP
        req_s = 2'b01;
        tick();
        en_in_s[0]   = 1'b1;
        data_in_s[0] = 8'hA1;
        tick();
        i2c_st_s = SEND;
        tick();
        en_in_s[0] = 1'b0;
        tick();
        i2c_st_s = STOP;
        i2c_rd_s = 8'hA5;
        tick();
        chk("t5_rd0", rd_data_s[0], 32'hA5);
        chk("t5_rd1_kept", rd_data_s[1], 32'h22);
        en_in_s[0] = 1'b1;
        tick();
        chk("t5_still_gnt", gnt_s, 32'h1);
        chk("t5_chained_en", i2c_en_s, 32'd1);
        i2c_st_s = SEND;
        tick();
        en_in_s[0] = 1'b0;
        req_s      = 2'b00;
        tick();
        i2c_st_s = STOP;
        i2c_rd_s = 8'h5A;
        tick();
        tick();
        tick();
        chk("t5_released", gnt_s, 32'd0);
        chk("t5_rd0_second", rd_data_s[0], 32'h5A);
        i2c_st_s = HOLD;

        // 6: reset while active
        req_s = 2'b01;
        tick();
        en_in_s[0] = 1'b1;
        tick();
        chk("t6_active_busy", busy_s, 32'd1);
        rst_n_s = 1'b0;
        tick();
        rst_n_s = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt_s, 32'd0);
        chk("t6_rst_en", i2c_en_s, 32'd0);
        chk("t6_rst_busy", busy_s, 32'd0);
        chk("t6_rst_rd", rd_data_s, 32'd0);
        en_in_s = '0;
        req_s   = 2'b11;
        tick();
        chk("t6_ptr_after_rst", gnt_s, 32'h1);
        req_s = 2'b00;
        tick();
        rst_n_s = 1'b0;
        tick();
        rst_n_s = 1'b1;
        req_s   = 2'b10;
        tick();
        chk("t6_only_req1", gnt_s, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
